// File: rtl/aes_key_sched_if.sv
// aes_key_sched_if -- control, key-load and round-key read signals of the
// AES key schedule block. The abort line exists only when
// AES_KEY_SCHED_ABORT_EN is defined.
interface aes_key_sched_if;
    logic         start;
    logic [1:0]   mode;
    logic [255:0] key_in;
    logic         busy;
    logic         done;
    logic         err;
    logic         key_valid;
    logic         rk_rd_en;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
    logic         rk_rd_valid;
`ifdef AES_KEY_SCHED_ABORT_EN
    logic         abort;

    modport master (output start, mode, key_in, rk_rd_en, rk_rd_idx, abort,
                    input  busy, done, err, key_valid, rk_rd_data, rk_rd_valid);
    modport slave  (input  start, mode, key_in, rk_rd_en, rk_rd_idx, abort,
                    output busy, done, err, key_valid, rk_rd_data, rk_rd_valid);
`else
    modport master (output start, mode, key_in, rk_rd_en, rk_rd_idx,
                    input  busy, done, err, key_valid, rk_rd_data, rk_rd_valid);
    modport slave  (input  start, mode, key_in, rk_rd_en, rk_rd_idx,
                    output busy, done, err, key_valid, rk_rd_data, rk_rd_valid);
`endif
endinterface

// File: rtl/aes_key_sched.sv
// aes_key_sched -- AES-128/192/256 key expansion, one word per cycle into a
// 60-word schedule store, with a round-key read port (RD_REG cycles latency).
// Optional feature: define AES_KEY_SCHED_ABORT_EN to add the abort input.
module aes_key_sched #(
    parameter int MAX_NK = 8,
    parameter int RD_REG = 1
) (
    input logic            clk,
    input logic            rst_n,
    aes_key_sched_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_EXPAND = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;
    localparam logic [3:0] MAX_NK_L = 4'(MAX_NK);

    logic [1:0]   state;
    logic [3:0]   nk_q;
    logic [3:0]   nr_q;
    logic [5:0]   cnt;
    logic [5:0]   last_q;
    logic [2:0]   ph;          // i mod Nk, tracked incrementally
    logic [7:0]   rcon;
    logic         done_q;
    logic         err_q;
    logic         kv_q;
    logic [255:0] key_q;
    logic [7:0][31:0] key_w;
    logic [31:0]  w_mem [0:59];

    // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[3'(i)]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box computed as affine(x^254); x^254 is the inverse, and maps 0 to 0
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 0; k < 7; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [3:0] mode_nk(input logic [1:0] m);
        case (m)
            2'b00:   return 4'd4;
            2'b01:   return 4'd6;
            2'b10:   return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    logic [3:0]   req_nk;
    logic         start_ok;
    logic         abort_req;
    logic [31:0]  w_prev;
    logic [31:0]  w_back;
    logic [31:0]  t_word;
    logic [31:0]  w_new;
    logic         rd_hit;
    logic [5:0]   rd_base;
    logic [127:0] rd_word;

    assign req_nk   = mode_nk(bus.mode);
    assign start_ok = (bus.mode != 2'b11) && (req_nk <= MAX_NK_L);
`ifdef AES_KEY_SCHED_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif
    assign key_w  = key_q;
    assign w_prev = w_mem[cnt - 6'd1];
    assign w_back = w_mem[cnt - {2'b00, nk_q}];

    // Next schedule word: w[i] = w[i-Nk] ^ t, t chosen by the position in the Nk cycle
    always_comb begin
        t_word = w_prev;
        if (ph == 3'd0)
            t_word = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {rcon, 24'h0};
        else if (nk_q == 4'd8 && ph == 3'd4)
            t_word = sub_word(w_prev);
        w_new = w_back ^ t_word;
    end

    // Control FSM: accept/reject starts, sequence load and expansion, flag completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            kv_q   <= 1'b0;
            cnt    <= 6'd0;
            ph     <= 3'd0;
            rcon   <= 8'h00;
            nk_q   <= 4'd0;
            nr_q   <= 4'd0;
            last_q <= 6'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (start_ok) begin
                            nk_q   <= req_nk;
                            nr_q   <= req_nk + 4'd6;
                            last_q <= {req_nk, 2'b00} + 6'd27;
                            kv_q   <= 1'b0;
                            state  <= S_LOAD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (abort_req) begin
                        state <= S_IDLE;
                    end else begin
                        cnt   <= {2'b00, nk_q};
                        ph    <= 3'd0;
                        rcon  <= 8'h01;
                        state <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    if (abort_req) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 6'd1;
                        ph  <= ({1'b0, ph} == nk_q - 4'd1) ? 3'd0 : ph + 3'd1;
                        if (ph == 3'd0) rcon <= xtime(rcon);
                        if (cnt == last_q) state <= S_DONE;
                    end
                end
                default: begin
                    done_q <= 1'b1;
                    kv_q   <= 1'b1;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    // Capture the key of an accepted start; low words beyond Nk are never loaded
    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.start && start_ok) key_q <= bus.key_in;
    end

    // Schedule store: Nk key words in one cycle, then one expanded word per cycle
    always_ff @(posedge clk) begin
        if (state == S_LOAD && !abort_req) begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < nk_q) w_mem[6'(k)] <= key_w[3'(7 - k)];
            end
        end else if (state == S_EXPAND && !abort_req) begin
            w_mem[cnt] <= w_new;
        end
    end

    assign bus.busy      = (state == S_LOAD) || (state == S_EXPAND);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.key_valid = kv_q;

    assign rd_hit  = bus.rk_rd_en && kv_q && (bus.rk_rd_idx <= nr_q);
    assign rd_base = rd_hit ? {bus.rk_rd_idx, 2'b00} : 6'd0;
    assign rd_word = {w_mem[rd_base], w_mem[rd_base + 6'd1],
                      w_mem[rd_base + 6'd2], w_mem[rd_base + 6'd3]};

    generate
        if (RD_REG != 0) begin : g_rd_reg
            logic [127:0] rd_data_p1;
            logic         rd_vld_p1;
            // Registered read port: zero data whenever the read is not honoured
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_p1 <= 128'h0;
                    rd_vld_p1  <= 1'b0;
                end else begin
                    rd_vld_p1  <= rd_hit;
                    rd_data_p1 <= rd_hit ? rd_word : 128'h0;
                end
            end
            assign bus.rk_rd_data  = rd_data_p1;
            assign bus.rk_rd_valid = rd_vld_p1;
        end else begin : g_rd_comb
            assign bus.rk_rd_data  = rd_hit ? rd_word : 128'h0;
            assign bus.rk_rd_valid = rd_hit;
        end
    endgenerate
endmodule

// File: tb/tb_aes_key_sched.sv
// tb_aes_key_sched -- directed and randomized checks of aes_key_sched against
// a FIPS-197 key expansion model. Abort checks need AES_KEY_SCHED_ABORT_EN.
module tb_aes_key_sched;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aes_key_sched_if bus();
    aes_key_sched #(.MAX_NK(8), .RD_REG(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    int ntests = 0;
    int nfail  = 0;
    logic [7:0]  sbox_t [256];
    logic [31:0] ref_w  [60];

    // polynomial product then reduction by 0x11b
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ ({7'b0, a} << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    function automatic void build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                       ^ inv[(i + 7) % 8] ^ c[i];
            sbox_t[x] = s;
        end
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Rcon[j] = x^(j-1) in GF(2^8)
    function automatic logic [7:0] rcon_of(input int j);
        logic [7:0] r;
        r = 8'h01;
        for (int k = 1; k < j; k++) r = gmul(r, 8'h02);
        return r;
    endfunction

    function automatic void model_expand(input logic [255:0] key, input int nk);
        int total;
        logic [31:0] t;
        total = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) ref_w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < total; i++) begin
            t = ref_w[i - 1];
            if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_of(i / nk), 24'h0};
            else if (nk == 8 && i % 8 == 4) t = subw(t);
            ref_w[i] = ref_w[i - nk] ^ t;
        end
    endfunction

    function automatic logic [127:0] ref_rk(input int r);
        return {ref_w[4 * r], ref_w[4 * r + 1], ref_w[4 * r + 2], ref_w[4 * r + 3]};
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r = {r[223:0], 32'($urandom())};
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [1:0] m, input logic [255:0] k);
        bus.mode   = m;
        bus.key_in = k;
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
        chk("busy_after_start", 128'(bus.busy), 128'd1);
    endtask

    // edges counted from the start edge until done is seen; -1 if never
    task automatic wait_done(output int n);
        n = -1;
        for (int c = 1; c <= 100; c++) begin
            step();
            if (bus.done === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    task automatic rd(input int idx, output logic [127:0] d, output logic v);
        bus.rk_rd_en  = 1'b1;
        bus.rk_rd_idx = 4'(idx);
        step();
        d = bus.rk_rd_data;
        v = bus.rk_rd_valid;
        bus.rk_rd_en  = 1'b0;
    endtask

    task automatic check_sched(input int nk, input string tag);
        logic [127:0] d;
        logic v;
        for (int r = 0; r <= nk + 6; r++) begin
            rd(r, d, v);
            chk($sformatf("%s_vld%0d", tag, r), 128'(v), 128'd1);
            chk($sformatf("%s_rk%0d", tag, r), d, ref_rk(r));
        end
        rd(nk + 7, d, v);
        chk($sformatf("%s_oor_vld", tag), 128'(v), 128'd0);
        chk($sformatf("%s_oor_data", tag), d, 128'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] key;
        logic [255:0] key2;
        logic [127:0] d;
        logic v;
        int n;
        int dcount;

        build_sbox();
        bus.start = 1'b0; bus.mode = 2'b00; bus.key_in = '0;
        bus.rk_rd_en = 1'b0; bus.rk_rd_idx = 4'd0;
`ifdef AES_KEY_SCHED_ABORT_EN
        bus.abort = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_busy", 128'(bus.busy), 128'd0);
        chk("rst_done", 128'(bus.done), 128'd0);
        chk("rst_err", 128'(bus.err), 128'd0);
        chk("rst_kv", 128'(bus.key_valid), 128'd0);
        chk("rst_rdv", 128'(bus.rk_rd_valid), 128'd0);
        chk("rst_rdd", bus.rk_rd_data, 128'h0);
        rst_n = 1'b1;
        step();
        rd(0, d, v);
        chk("empty_rd_vld", 128'(v), 128'd0);
        chk("empty_rd_data", d, 128'h0);

        // AES-128 known vector, garbage in unused key bits
        key = K128 ^ {128'h0, rand256() >> 128};
        start_run(2'b00, key);
        wait_done(n);
        chk("lat128", 128'(n), 128'd42);
        chk("busy_at_done", 128'(bus.busy), 128'd0);
        chk("kv_at_done", 128'(bus.key_valid), 128'd1);
        step();
        chk("done_pulse", 128'(bus.done), 128'd0);
        rd(10, d, v);
        chk("kat128_rk10", d, R128_10);
        rd(0, d, v);
        chk("kat128_rk0", d, K128[255:128]);
        model_expand(key, 4);
        check_sched(4, "a128");

        // illegal mode rejected, old schedule kept
        bus.mode = 2'b11; bus.key_in = rand256(); bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("ill_err", 128'(bus.err), 128'd1);
        chk("ill_busy", 128'(bus.busy), 128'd0);
        step();
        chk("ill_err_clr", 128'(bus.err), 128'd0);
        chk("ill_kv", 128'(bus.key_valid), 128'd1);
        rd(10, d, v);
        chk("ill_rk10", d, R128_10);

        // read in the accepted-start cycle comes from the old schedule
        key = rand256();
        bus.mode = 2'b00; bus.key_in = key; bus.start = 1'b1;
        bus.rk_rd_en = 1'b1; bus.rk_rd_idx = 4'd10;
        step();
        bus.start = 1'b0; bus.rk_rd_en = 1'b0;
        chk("samecyc_vld", 128'(bus.rk_rd_valid), 128'd1);
        chk("samecyc_data", bus.rk_rd_data, R128_10);
        chk("samecyc_kv", 128'(bus.key_valid), 128'd0);
        wait_done(n);
        chk("samecyc_lat", 128'(n), 128'd42);
        model_expand(key, 4);
        check_sched(4, "s128");

        // start during EXPAND ignored
        key = rand256();
        start_run(2'b00, key);
        repeat (9) step();
        bus.mode = 2'b10; bus.key_in = rand256(); bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("ign_err", 128'(bus.err), 128'd0);
        chk("ign_busy", 128'(bus.busy), 128'd1);
        wait_done(n);
        chk("ign_lat", 128'(n), 128'd32);
        model_expand(key, 4);
        check_sched(4, "i128");

        // AES-192 and AES-256 known vectors
        start_run(2'b01, K192);
        wait_done(n);
        chk("lat192", 128'(n), 128'd48);
        rd(12, d, v);
        chk("kat192_rk12", d, R192_12);
        model_expand(K192, 6);
        check_sched(6, "a192");
        start_run(2'b10, K256);
        wait_done(n);
        chk("lat256", 128'(n), 128'd54);
        rd(14, d, v);
        chk("kat256_rk14", d, R256_14);
        model_expand(K256, 8);
        check_sched(8, "a256");

        // random keys, all modes
        for (int it = 0; it < 6; it++) begin
            key = rand256();
            start_run(2'(it % 3), key);
            wait_done(n);
            chk($sformatf("rnd%0d_lat", it), 128'(n), 128'(42 + 6 * (it % 3)));
            model_expand(key, 4 + 2 * (it % 3));
            check_sched(4 + 2 * (it % 3), $sformatf("rnd%0d", it));
        end

        // reset mid-expansion
        start_run(2'b10, rand256());
        repeat (19) step();
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 128'(bus.busy), 128'd0);
        chk("mrst_kv", 128'(bus.key_valid), 128'd0);
        chk("mrst_done", 128'(bus.done), 128'd0);
        step();
        rst_n = 1'b1;
        step();
        rd(0, d, v);
        chk("mrst_rd_vld", 128'(v), 128'd0);
        chk("mrst_rd_data", d, 128'h0);

`ifdef AES_KEY_SCHED_ABORT_EN
        // abort an AES-256 run, then a clean run
        start_run(2'b10, rand256());
        repeat (9) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abort_busy", 128'(bus.busy), 128'd0);
        chk("abort_kv", 128'(bus.key_valid), 128'd0);
        dcount = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (bus.done === 1'b1) dcount++;
        end
        chk("abort_nodone", 128'(dcount), 128'd0);
        key2 = rand256();
        start_run(2'b10, key2);
        wait_done(n);
        chk("abort_relat", 128'(n), 128'd54);
        model_expand(key2, 8);
        check_sched(8, "ab256");
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/aes_key_sched.md
AES_KEY_SCHED -- requirements
Module: aes_key_sched

Interface
REQ-001 SHALL have parameter MAX_NK, default 8, meaning the largest key length in words the block supports (legal values 4, 6, 8).
REQ-002 SHALL have parameter RD_REG, default 1, meaning the read-port latency in cycles (legal values 0, 1).
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to expand key_in.
REQ-006 SHALL have port mode, input, 2 bits, sampled with start: 00 = AES-128 (Nk=4, Nr=10); 01 = AES-192 (Nk=6, Nr=12); 10 = AES-256 (Nk=8, Nr=14); 11 = illegal.
REQ-007 SHALL have port key_in, input, 256 bits, MSB-aligned: w[0] = key_in[255:224]; unused low bits are ignored.
REQ-008 SHALL have port busy, output, 1 bit: expansion in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when the schedule is complete.
REQ-010 SHALL have port err, output, 1 bit: one-cycle pulse when a start is rejected.
REQ-011 SHALL have port key_valid, output, 1 bit: the stored schedule is complete and readable.
REQ-012 SHALL have port rk_rd_en, input, 1 bit: round-key read strobe.
REQ-013 SHALL have port rk_rd_idx, input, 4 bits: round number 0..Nr.
REQ-014 SHALL have port rk_rd_data, output, 128 bits: {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in [127:96].
REQ-015 SHALL have port rk_rd_valid, output, 1 bit: rk_rd_data is valid.

Function
REQ-016 SHALL implement FSM IDLE -> LOAD -> EXPAND -> DONE -> IDLE, with storage for 60 32-bit words.
REQ-017 In IDLE, start=1 with a legal mode SHALL latch mode and key_in, clear key_valid, and enter LOAD on the next edge.
REQ-018 LOAD SHALL write words w[0..Nk-1] in a single cycle, set the word counter to Nk and Rcon to 8'h01, then enter EXPAND.
REQ-019 EXPAND SHALL write exactly one word per cycle, w[i] for i = Nk .. 4(Nr+1)-1 (last i = 43, 51 or 59), where w[i] = w[i-Nk] ^ t.
REQ-020 The term t SHALL be:
- i%Nk==0: SubWord(RotWord(w[i-1])) ^ {Rcon,24'h0}.
- Nk==8 and i%8==4: SubWord(w[i-1]).
- otherwise: w[i-1].
REQ-021 Rcon SHALL advance via xtime after each i%Nk==0 word (01,02,04,...,80,1b,36); no table SHALL be used.
REQ-022 After the last word, the FSM SHALL enter DONE for one cycle: done=1, key_valid set, then return to IDLE.
REQ-023 Latency: if start is sampled at edge T, done SHALL be high in the cycle following edge T+42 / T+48 / T+54 for modes 00 / 01 / 10.
REQ-024 busy SHALL be 1 in LOAD and EXPAND, 0 in IDLE and DONE.
REQ-025 start while busy or in DONE SHALL be ignored: no err, no effect.
REQ-026 start with mode=11, or with mode requiring Nk > MAX_NK, SHALL pulse err the next cycle, remain in IDLE, and leave key_valid and stored words unchanged.
REQ-027 Read: rk_rd_en=1 with key_valid=1 and rk_rd_idx <= latched Nr SHALL return the round key after RD_REG cycles with rk_rd_valid=1.
REQ-028 Otherwise rk_rd_valid SHALL be 0 and rk_rd_data SHALL be 128'h0.
REQ-029 A read in the same cycle as an accepted start SHALL be served from the old schedule, because key_valid clears only at the following edge.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE and clear busy, done, err, key_valid, rk_rd_valid, rk_rd_data, the counter and Rcon to 0.
REQ-031 Reset mid-expansion SHALL abandon the run; stored words need not be cleared, but key_valid=0 SHALL block reads.

Configuration
REQ-032 With macro AES_KEY_SCHED_ABORT_EN defined, the block SHALL add input abort (1 bit).
REQ-033 abort=1 in LOAD or EXPAND SHALL return the FSM to IDLE on the next edge with key_valid=0 and no done; abort SHALL have priority over the word write in that cycle.
REQ-034 Without AES_KEY_SCHED_ABORT_EN, the abort port SHALL be absent and the behaviour SHALL be exactly as above.

Verification
REQ-035 mode=00, key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> done 42 cycles after start; read idx 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6; idx 0 = key.
REQ-036 mode=01, key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> done after 48 cycles; idx 12 = e98ba06f 448c773c 8ecc7204 01002202.
REQ-037 mode=10, key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> done after 54 cycles; idx 14 = fe4890d1 e6188d0b 046df344 706c631e.
REQ-038 mode=11 start -> err pulse one cycle later, busy stays 0, previous key_valid=1 and read idx 10 unchanged.
REQ-039 Second start during EXPAND -> ignored, done still at cycle 42 of the first run; rst_n low at cycle 20 -> busy=0, key_valid=0, read idx 0 gives rk_rd_valid=0.
REQ-040 With AES_KEY_SCHED_ABORT_EN: abort at cycle 10 of an AES-256 run -> IDLE, no done; a new start then completes correctly after 54 cycles.
